// File: rtl/l2c_lru_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | l2c_lru_pkg : shared types/constants for the L2C LRU controller  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package l2c_lru_pkg;

  localparam int WAYS      = 8;
  localparam int AGE_W     = 3;
  localparam int WAY_IDX_W = 3;
  localparam int ENTRY_W   = 32;
  localparam int AGE_LSB   = 0;
  localparam int V_LSB     = WAYS * AGE_W;

  typedef logic [ENTRY_W-1:0] lru_entry_t;

  typedef enum logic [1:0] {
    LRU_LOOKUP  = 2'b00,
    LRU_HIT     = 2'b01,
    LRU_REPLACE = 2'b10,
    LRU_INVAL   = 2'b11
  } lru_op_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } ctl_state_e;

  function automatic logic [WAYS-1:0] lowest_one(input logic [WAYS-1:0] vec);
    return vec & (~vec + {{(WAYS-1){1'b0}}, 1'b1});
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2c_lru_ctl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | l2c_lru_ctl_if : request/response bus of the LRU controller      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface l2c_lru_ctl_if
  import l2c_lru_pkg::*;
#(
  parameter int SET_W = 8
) ();

  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [SET_W-1:0] req_set;
  lru_op_e          req_op;
  logic [WAYS-1:0]  req_mask;
  logic             rsp_valid;
  logic [WAYS-1:0]  rsp_way_msk;
  logic [WAYS-1:0]  rsp_v;
  logic             busy;

  modport master (
    output flush, req_valid, req_set, req_op, req_mask,
    input  req_ready, rsp_valid, rsp_way_msk, rsp_v, busy
  );

  modport slave (
    input  flush, req_valid, req_set, req_op, req_mask,
    output req_ready, rsp_valid, rsp_way_msk, rsp_v, busy
  );

endinterface
`default_nettype wire

// File: rtl/l2c_lru_age_upd.sv
`default_nettype none
// +------------------------------------------------------------------+
// | l2c_lru_age_upd : combinational next-state for one LRU set entry |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module l2c_lru_age_upd
  import l2c_lru_pkg::*;
(
  input  lru_entry_t      entry,
  input  lru_op_e         op,
  input  logic [WAYS-1:0] mask,
  output lru_entry_t      new_entry,
  output logic [WAYS-1:0] way_msk
);

  logic [WAYS-1:0]      v;
  logic [WAYS-1:0]      v_n;
  logic [AGE_W-1:0]     age   [WAYS];
  logic [AGE_W-1:0]     age_n [WAYS];
  logic [WAYS-1:0]      hit_oh;
  logic [AGE_W-1:0]     hit_age;
  logic [WAYS-1:0]      inv_oh;
  logic [WAYS-1:0]      max_oh;
  logic [WAYS-1:0]      victim_oh;
  logic [AGE_W-1:0]     best_age;
  logic [WAY_IDX_W-1:0] best_idx;

  always_comb begin
    v = entry[V_LSB +: WAYS];
    for (int i = 0; i < WAYS; i++) begin
      age[i] = entry[AGE_LSB + i*AGE_W +: AGE_W];
    end

    hit_oh  = lowest_one(mask);
    hit_age = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (hit_oh[i]) hit_age = age[i];
    end

    // strict '>' keeps the lowest index on equal ages
    best_age = age[0];
    best_idx = '0;
    for (int i = 1; i < WAYS; i++) begin
      if (age[i] > best_age) begin
        best_age = age[i];
        best_idx = WAY_IDX_W'(i);
      end
    end
    max_oh           = '0;
    max_oh[best_idx] = 1'b1;
    inv_oh           = lowest_one(~v);
    victim_oh        = (&v) ? max_oh : inv_oh;
  end

  always_comb begin
    v_n     = v;
    way_msk = '0;
    for (int i = 0; i < WAYS; i++) begin
      age_n[i] = age[i];
    end

    case (op)
      LRU_HIT: begin
        if (|mask) begin
          for (int i = 0; i < WAYS; i++) begin
            if (hit_oh[i]) begin
              age_n[i] = '0;
            end else if (v[i] && (age[i] < hit_age)) begin
              age_n[i] = age[i] + AGE_W'(1);
            end
          end
        end
      end
      LRU_REPLACE: begin
        way_msk = victim_oh;
        for (int i = 0; i < WAYS; i++) begin
          if (victim_oh[i]) begin
            age_n[i] = '0;
            v_n[i]   = 1'b1;
          end else if (v[i] && (age[i] != {AGE_W{1'b1}})) begin
            age_n[i] = age[i] + AGE_W'(1);
          end
        end
      end
      LRU_INVAL: begin
        v_n = v & ~mask;
        for (int i = 0; i < WAYS; i++) begin
          if (mask[i]) age_n[i] = '0;
        end
      end
      default: begin
      end
    endcase

    new_entry                = '0;
    new_entry[V_LSB +: WAYS] = v_n;
    for (int i = 0; i < WAYS; i++) begin
      new_entry[AGE_LSB + i*AGE_W +: AGE_W] = age_n[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2c_lru_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | l2c_lru_ram : 1R1W synchronous RAM, read-old-data on collision   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module l2c_lru_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/l2c_lru_ctl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | l2c_lru_ctl : per-set LRU/valid controller, 2-stage RMW pipeline |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module l2c_lru_ctl
  import l2c_lru_pkg::*;
#(
  parameter int SET_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  l2c_lru_ctl_if.slave bus
);

  ctl_state_e       state;
  logic [SET_W-1:0] sweep_cnt;
  logic             ready_q;
  logic             busy_q;
  logic             accept;

  logic             s1_valid;
  logic [SET_W-1:0] s1_set;
  lru_op_e          s1_op;
  logic [WAYS-1:0]  s1_mask;
  logic             byp_sel;
  lru_entry_t       byp_entry;

  lru_entry_t       ram_rdata;
  lru_entry_t       s1_entry;
  lru_entry_t       upd_entry;
  logic [WAYS-1:0]  upd_way_msk;
  logic             ram_we;
  logic [SET_W-1:0] ram_waddr;
  lru_entry_t       ram_wdata;

  logic             rsp_valid_q;
  logic [WAYS-1:0]  rsp_way_msk_q;
  logic [WAYS-1:0]  rsp_v_q;

  // flush must close the request window in the very cycle it is raised
  assign bus.req_ready   = ready_q & ~bus.flush;
  assign bus.busy        = busy_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_way_msk = rsp_way_msk_q;
  assign bus.rsp_v       = rsp_v_q;
  assign accept          = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
          if (sweep_cnt == {SET_W{1'b1}}) begin
            state     <= ST_RUN;
            sweep_cnt <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            sweep_cnt <= sweep_cnt + SET_W'(1);
          end
        end
        ST_RUN: begin
          if (bus.flush) begin
            state   <= ST_DRAIN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!s1_valid) state <= ST_INIT;
        end
        default: begin
          state   <= ST_INIT;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // the RAM misses the write landing in the same edge as the read; the bypass covers it
  assign s1_entry  = byp_sel ? byp_entry : ram_rdata;
  assign ram_we    = (state == ST_INIT) | s1_valid;
  assign ram_waddr = (state == ST_INIT) ? sweep_cnt : s1_set;
  assign ram_wdata = (state == ST_INIT) ? '0 : upd_entry;

  l2c_lru_ram #(
    .ADDR_W (SET_W),
    .DATA_W (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (accept),
    .raddr (bus.req_set),
    .rdata (ram_rdata)
  );

  l2c_lru_age_upd u_upd (
    .entry     (s1_entry),
    .op        (s1_op),
    .mask      (s1_mask),
    .new_entry (upd_entry),
    .way_msk   (upd_way_msk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_set        <= '0;
      s1_op         <= LRU_LOOKUP;
      s1_mask       <= '0;
      byp_sel       <= 1'b0;
      byp_entry     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_way_msk_q <= '0;
      rsp_v_q       <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_set  <= bus.req_set;
        s1_op   <= bus.req_op;
        s1_mask <= bus.req_mask;
      end
      byp_sel <= accept & s1_valid & (s1_set == bus.req_set);
      if (accept) byp_entry <= upd_entry;

      rsp_valid_q   <= s1_valid;
      rsp_way_msk_q <= s1_valid ? upd_way_msk : '0;
      rsp_v_q       <= s1_valid ? upd_entry[V_LSB +: WAYS] : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2c_lru_ctl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_l2c_lru_ctl : scoreboard bench for the LRU controller         |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_l2c_lru_ctl;
  import l2c_lru_pkg::*;

  typedef struct {
    logic [7:0] msk;
    logic [7:0] v;
    int         cyc;
    int         id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_sent  = 0;
  int   rsp_seen = 0;
  int   cyc = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2c_lru_ctl_if #(.SET_W(8)) bus ();

  l2c_lru_ctl #(.SET_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid) rsp_seen = rsp_seen + 1;
    if (rst_n && bus.rsp_valid) begin
      n_tests = n_tests + 1;
      if (q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_rsp: got msk=%02h v=%02h, required no response", bus.rsp_way_msk, bus.rsp_v);
      end else begin
        e = q.pop_front();
        if (bus.rsp_way_msk !== e.msk || bus.rsp_v !== e.v || cyc != e.cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL rsp#%0d: got msk=%02h v=%02h cyc=%0d, required msk=%02h v=%02h cyc=%0d",
                   e.id, bus.rsp_way_msk, bus.rsp_v, cyc, e.msk, e.v, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // entered just after a rising edge; returns just after the accepting edge
  task automatic send(input lru_op_e op, input int set, input logic [7:0] mask,
                      input logic [7:0] emsk, input logic [7:0] ev);
    int   tries;
    logic acc;
    tries = 0;
    acc   = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_set   = 8'(set);
    bus.req_mask  = mask;
    while (!acc && tries < 1000) begin
      @(negedge clk);
      if (bus.req_ready) begin
        q.push_back('{msk: emsk, v: ev, cyc: cyc + 2, id: n_sent});
        n_sent = n_sent + 1;
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) begin
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL send_timeout: got ready=0, required ready=1");
    end
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_q();
    int t;
    t = 0;
    bus.req_valid = 1'b0;
    while (q.size() != 0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic wait_ready(output int k);
    k = 0;
    while (!bus.req_ready && k < 2000) begin
      if (k == 128) chk("busy_during_sweep", 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    int k;
    int seen0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_set   = '0;
    bus.req_op    = LRU_LOOKUP;
    bus.req_mask  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_data", 32'({bus.rsp_way_msk, bus.rsp_v}), 32'd0);

    rst_n = 1'b1;
    wait_ready(k);
    chk("init_ready_rise", 32'(k), 32'd256);

    send(LRU_LOOKUP, 5, 8'h00, 8'h00, 8'h00);
    drain_q();

    // fill set 3: victims ascend, ages end 7..0 for way0..7
    for (int i = 0; i < 8; i++) send(LRU_REPLACE, 3, 8'h00, 8'(1 << i), 8'((2 << i) - 1));
    send(LRU_REPLACE, 3, 8'h00, 8'h01, 8'hFF);
    drain_q();

    for (int i = 0; i < 8; i++) send(LRU_REPLACE, 4, 8'h00, 8'(1 << i), 8'((2 << i) - 1));
    send(LRU_HIT, 4, 8'h01, 8'h00, 8'hFF);
    send(LRU_REPLACE, 4, 8'h00, 8'h02, 8'hFF);
    send(LRU_HIT, 4, 8'h0C, 8'h00, 8'hFF);
    send(LRU_REPLACE, 4, 8'h00, 8'h08, 8'hFF);
    send(LRU_HIT, 4, 8'h00, 8'h00, 8'hFF);
    send(LRU_REPLACE, 4, 8'h00, 8'h10, 8'hFF);

    send(LRU_INVAL, 3, 8'h24, 8'h00, 8'hDB);
    send(LRU_REPLACE, 3, 8'h00, 8'h04, 8'hDF);
    send(LRU_LOOKUP, 200, 8'h00, 8'h00, 8'h00);

    // same set two cycles apart: update must come back through the RAM
    send(LRU_REPLACE, 7, 8'h00, 8'h01, 8'h01);
    send(LRU_LOOKUP, 8, 8'h00, 8'h00, 8'h00);
    send(LRU_REPLACE, 7, 8'h00, 8'h02, 8'h03);
    drain_q();

    send(LRU_LOOKUP, 3, 8'h00, 8'h00, 8'hDF);
    send(LRU_LOOKUP, 4, 8'h00, 8'h00, 8'hFF);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = LRU_REPLACE;
    bus.req_set   = 8'd9;
    @(negedge clk);
    chk("flush_ready_low", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd1);
    wait_ready(k);
    chk("flush_ready_low_span", 32'((k >= 256) && (k <= 260)), 32'd1);
    chk("flush_inflight_delivered", 32'(q.size()), 32'd0);

    send(LRU_LOOKUP, 3, 8'h00, 8'h00, 8'h00);
    send(LRU_LOOKUP, 4, 8'h00, 8'h00, 8'h00);
    send(LRU_LOOKUP, 9, 8'h00, 8'h00, 8'h00);
    drain_q();

    // reset with a request in flight, then again mid-sweep
    send(LRU_REPLACE, 10, 8'h00, 8'h01, 8'h01);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    q.delete();
    seen0 = rsp_seen;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(k);
    chk("rerst_ready_rise", 32'(k), 32'd256);
    chk("rerst_no_rsp", 32'(rsp_seen - seen0), 32'd0);

    send(LRU_LOOKUP, 10, 8'h00, 8'h00, 8'h00);
    send(LRU_REPLACE, 10, 8'h00, 8'h01, 8'h01);
    idle();
    drain_q();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2c_lru_ctl.md
Name: l2c_lru_ctl

Overview:
- Per-set LRU state controller for the 8-way L2C tag path.
- Owns the LRU/valid RAM: per set, 8 valid bits plus 8 x 3-bit ages.
- Accepts one set-indexed request per cycle (lookup, hit-promote, replace, invalidate), performs read-modify-write through a 2-stage pipeline with same-set bypass, and returns the victim way mask and updated valid bits.
- Sweeps all sets to the empty state after reset and on flush.

Parameters:
- SET_W, 8, set index width; RAM depth 2^SET_W entries of 32 bits ({V[7:0], age7..age0}).

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-low reset
- i_flush  in  1  pulse: invalidate all sets
- i_req_valid  in  1  request strobe
- o_req_ready  out  1  request accepted when i_req_valid & o_req_ready
- i_req_set  in  SET_W  set index
- i_req_op  in  2  00 LOOKUP, 01 HIT, 10 REPLACE, 11 INVAL
- i_req_mask  in  8  HIT: hit way (one-hot); INVAL: ways to invalidate
- o_rsp_valid  out  1  response strobe (no backpressure)
- o_rsp_way_msk  out  8  one-hot victim for REPLACE, else 0
- o_rsp_V  out  8  valid bits of the set after update
- o_busy  out  1  init/flush sweep or drain in progress

Behaviour:
- Reset (Reset=0):
  - All outputs 0, FSM enters INIT, sweep counter 0.
  - Reset asserted mid-sweep or mid-pipeline restarts the sweep; in-flight requests are dropped with no response.
- FSM states: INIT, RUN, DRAIN.
  - INIT: writes 32'h0 to set = counter each cycle; o_busy=1; o_req_ready=0. After set 2^SET_W-1 is written, go to RUN. o_req_ready rises 2^SET_W cycles after Reset deasserts.
  - RUN: o_req_ready=1, o_busy=0.
  - i_flush in RUN: o_req_ready drops the same cycle; a request presented that cycle is not accepted. FSM goes to DRAIN until both pipeline stages are empty (at most 2 cycles), then to INIT.
  - i_flush during INIT or DRAIN: ignored.
- Pipeline:
  - S0 (accept cycle T): synchronous RAM read of i_req_set.
  - S1 (T+1): compute the new state and write it back to the RAM.
  - Response registered: o_rsp_valid, o_rsp_way_msk and o_rsp_V visible at T+2 for one cycle.
  - Throughput: 1 request per cycle.
- Same-set bypass:
  - If the S1 write set equals the set of the request entering S1 next cycle, the S1 next-state replaces the RAM read data.
  - Back-to-back same-set requests therefore observe each other's updates.
- Update rules (V = valid bits, a[i] = 3-bit age):
  - LOOKUP: no change; way_msk=0.
  - HIT: h = lowest set bit of the mask; mask=0 means no change. a[h]=0. Every valid i!=h with a[i] < old a[h] gets a[i]+1. V unchanged; way_msk=0.
  - REPLACE: victim = lowest-index invalid way if any V=0; otherwise the max-age way, ties to the lowest index. a[victim]=0 and V[victim]=1. Every other valid way increments its age, saturating at 7. way_msk = one-hot victim.
  - INVAL: for each mask bit set, V=0 and a=0. Others unchanged; way_msk=0.
- Invariants and limits:
  - Ages of valid ways stay distinct under HIT/REPLACE from the empty state.
  - Ages are never wrapped; 3-bit arithmetic saturates at 7.

Decomposition:
- Shared package l2c_lru_pkg:
  - op codes LRU_LOOKUP/HIT/REPLACE/INVAL
  - WAYS=8, AGE_W=3, entry width 32
  - entry field offsets
- Sub-module l2c_lru_age_upd: purely combinational; inputs entry, op, mask; outputs new entry and way_msk.
- Sub-module l2c_lru_ram: 1R1W synchronous RAM, read-old-data on same-address collision (the bypass covers it).
- Controller holds the FSM, pipeline registers and bypass mux.

Test Plan:
- Reset release, SET_W=8: o_req_ready=0 for 256 cycles, then 1; LOOKUP set 5 -> rsp at T+2, V=8'h00, way_msk=0.
- 8 REPLACEs to set 3, back-to-back: way_msk = 01,02,04,...,80. Final V=FF, ages way0..7 = 7,6,5,4,3,2,1,0. A 9th REPLACE -> way_msk=8'h01.
- After the fill: HIT mask=8'h01 then REPLACE, same set, consecutive cycles -> HIT gives way0 age 0 and ways1..7 ages 7..1. REPLACE (via bypass) gives way_msk=8'h02.
- INVAL set 3 mask=8'h24, then REPLACE -> V=8'hDB after INVAL; REPLACE way_msk=8'h04 (lowest invalid), V=8'hDF.
- i_flush with 2 requests in flight -> both responses delivered, o_busy=1, o_req_ready=0 for 256+ cycles; a subsequent LOOKUP on any set -> V=0.
- Reset asserted at sweep index 100 -> sweep restarts; o_req_ready rises exactly 256 cycles after the second deassert; no o_rsp_valid during that time.
